// File: rtl/tile_match_ctrl.sv
// ----------------------------------------------------------------------------
// tile_match_ctrl
// Controller for a 4x4 "memory" tile-matching game. The player moves a
// cursor with the four direction buttons. Select reveals the tile under the
// cursor, and a second select reveals another tile. Equal symbols are marked
// matched and the score goes up. Unequal symbols stay visible for
// MISMATCH_CYCLES cycles and are then hidden again. The board lives in an
// external RAM with a one-cycle read latency; this block only issues reads
// and single-cycle writes.
//
// Optional feature: define MOVE_COUNTER_EN to count attempted pairs on
// 'moves'. Without it, 'moves' is tied to zero.
//
// Parameters:
//   MISMATCH_CYCLES  cycles both tiles of a failed pair stay revealed
//   PAIRS            matched-pair count that ends the game
//
// Ports:
//   clock50MHz       single clock, rising edge
//   resetn           asynchronous active-low reset
//   btnUp/Down/Left/Right/Sel  level buttons, active-high
//   ramAddr          tile address to RAM port A
//   ramWrData        tile byte {revealed, matched, symbol[5:0]}
//   ramWe            one-cycle write enable
//   ramRdData        RAM read data, valid one cycle after ramAddr
//   cursor           cursor tile index {row, column}
//   score            matched pairs
//   done             high once score reaches PAIRS
//   busy             high outside IDLE and WAIT2
//   moves            attempted pairs (MOVE_COUNTER_EN only)
// ----------------------------------------------------------------------------
module tile_match_ctrl #(
    parameter int MISMATCH_CYCLES = 25000000,
    parameter int PAIRS           = 8
) (
    input  logic       clock50MHz,
    input  logic       resetn,
    input  logic       btnUp,
    input  logic       btnDown,
    input  logic       btnLeft,
    input  logic       btnRight,
    input  logic       btnSel,
    output logic [3:0] ramAddr,
    output logic [7:0] ramWrData,
    output logic       ramWe,
    input  logic [7:0] ramRdData,
    output logic [3:0] cursor,
    output logic [3:0] score,
    output logic       done,
    output logic       busy,
    output logic [7:0] moves
);

    typedef enum logic [3:0] {
        IDLE, RD1, CHK1, WAIT2, RD2, CHK2, WR_M1, WR_M2, SHOW, HIDE1, HIDE2
    } stateT;

    localparam int              ShowW    = (MISMATCH_CYCLES > 1) ? $clog2(MISMATCH_CYCLES) : 1;
    localparam logic [ShowW-1:0] ShowLast = ShowW'(MISMATCH_CYCLES - 1);
    localparam logic [3:0]       PairsMax = 4'(PAIRS);

    stateT            state;
    logic [4:0]       btnPrev;
    logic [4:0]       btnNow;
    logic [4:0]       press;
    logic             acceptInput;
    logic             selTake;
    logic [3:0]       cursorNext;
    logic [3:0]       tileA;
    logic [3:0]       tileB;
    logic [5:0]       symA;
    logic [5:0]       symB;
    logic [ShowW-1:0] showCnt;
    logic             tileTaken;

    // Bit order gives the priority used below: sel, up, down, left, right.
    assign btnNow      = {btnSel, btnUp, btnDown, btnLeft, btnRight};
    assign press       = btnNow & ~btnPrev;
    assign acceptInput = (state == IDLE) || (state == WAIT2);
    // A finished game ignores select, so a same-cycle move still goes through.
    assign selTake     = acceptInput && press[4] && !((state == IDLE) && done);
    assign tileTaken   = ramRdData[7] | ramRdData[6];

    // Cursor moves wrap inside the current row or column.
    always_comb begin
        cursorNext = cursor;
        if (acceptInput && !selTake) begin
            if (press[3])      cursorNext = {cursor[3:2] - 2'd1, cursor[1:0]};
            else if (press[2]) cursorNext = {cursor[3:2] + 2'd1, cursor[1:0]};
            else if (press[1]) cursorNext = {cursor[3:2], cursor[1:0] - 2'd1};
            else if (press[0]) cursorNext = {cursor[3:2], cursor[1:0] + 2'd1};
        end
    end

    // Game FSM. Every output is registered, so a write scheduled in a state
    // appears on the RAM port during the following cycle.
    always_ff @(posedge clock50MHz or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            btnPrev   <= '0;
            ramAddr   <= '0;
            ramWrData <= '0;
            ramWe     <= 1'b0;
            cursor    <= '0;
            score     <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            tileA     <= '0;
            tileB     <= '0;
            symA      <= '0;
            symB      <= '0;
            showCnt   <= '0;
`ifdef MOVE_COUNTER_EN
            moves     <= '0;
`endif
        end else begin
            btnPrev <= btnNow;
            ramWe   <= 1'b0;
            cursor  <= cursorNext;
            case (state)
                IDLE: begin
                    if (selTake) begin
                        tileA   <= cursor;
                        ramAddr <= cursor;
                        busy    <= 1'b1;
                        state   <= RD1;
                    end else begin
                        ramAddr <= cursorNext;
                    end
                end
                RD1: state <= CHK1;
                CHK1: begin
                    busy <= 1'b0;
                    if (tileTaken) begin
                        ramAddr <= cursor;
                        state   <= IDLE;
                    end else begin
                        ramWe     <= 1'b1;
                        ramAddr   <= tileA;
                        ramWrData <= {2'b10, ramRdData[5:0]};
                        symA      <= ramRdData[5:0];
                        state     <= WAIT2;
                    end
                end
                WAIT2: begin
                    if (selTake) begin
                        tileB   <= cursor;
                        ramAddr <= cursor;
                        busy    <= 1'b1;
                        state   <= RD2;
                    end else begin
                        ramAddr <= cursorNext;
                    end
                end
                RD2: state <= CHK2;
                CHK2: begin
                    // Re-selecting tile A lands here too: it already reads back revealed.
                    if (tileTaken) begin
                        ramAddr <= cursor;
                        busy    <= 1'b0;
                        state   <= WAIT2;
                    end else begin
                        ramWe     <= 1'b1;
                        ramAddr   <= tileB;
                        ramWrData <= {2'b10, ramRdData[5:0]};
                        symB      <= ramRdData[5:0];
`ifdef MOVE_COUNTER_EN
                        if (moves != 8'hFF) moves <= moves + 8'd1;
`endif
                        if (ramRdData[5:0] == symA) begin
                            state <= WR_M1;
                        end else begin
                            showCnt <= '0;
                            state   <= SHOW;
                        end
                    end
                end
                WR_M1: begin
                    ramWe     <= 1'b1;
                    ramAddr   <= tileA;
                    ramWrData <= {2'b11, symA};
                    state     <= WR_M2;
                end
                WR_M2: begin
                    ramWe     <= 1'b1;
                    ramAddr   <= tileB;
                    ramWrData <= {2'b11, symB};
                    if (score < PairsMax) score <= score + 4'd1;
                    done      <= (score + 4'd1 >= PairsMax);
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                SHOW: begin
                    if (showCnt == ShowLast) state <= HIDE1;
                    else                     showCnt <= showCnt + 1'b1;
                end
                HIDE1: begin
                    ramWe     <= 1'b1;
                    ramAddr   <= tileA;
                    ramWrData <= {2'b00, symA};
                    state     <= HIDE2;
                end
                HIDE2: begin
                    ramWe     <= 1'b1;
                    ramAddr   <= tileB;
                    ramWrData <= {2'b00, symB};
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifndef MOVE_COUNTER_EN
    assign moves = 8'd0;
`endif

endmodule
